// File: rtl/acc_to_bf16_pipe_if.sv
// Handshake bundle for acc_to_bf16_pipe: accumulator beats in, packed bf16 beats and flags out.
// The slave modport is the converter side; the master modport is the producer/consumer side.
`timescale 1ns/1ps
interface acc_to_bf16_pipe_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 20
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ACC_W-1:0] in_acc;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*16-1:0]    out_bf16;
    logic [LANES-1:0]       out_ovf;
    logic [LANES-1:0]       out_unf;

    modport master (
        output in_valid, in_acc, out_ready,
        input  in_ready, out_valid, out_bf16, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_acc, out_ready,
        output in_ready, out_valid, out_bf16, out_ovf, out_unf
    );
endinterface

// File: rtl/acc_to_bf16_pipe.sv
// Two-stage, multi-lane signed accumulator to bfloat16 converter with valid/ready flow control.
// Define ACC_BF16_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
`timescale 1ns/1ps
module acc_to_bf16_pipe #(
    parameter int LANES      = 4,
    parameter int ACC_W      = 20,
    parameter int EXP_OFFSET = 24
) (
    input logic               clk,
    input logic               rst,
    acc_to_bf16_pipe_if.slave bus
);
    localparam int LW = $clog2(ACC_W);
    // Normalised magnitude carries 9 extra zero LSBs so mantissa, guard and sticky
    // always have bits to select, even for narrow accumulators.
    localparam int NW = ACC_W + 9;
    localparam logic signed [9:0] EXP_BIAS = 10'(127 - EXP_OFFSET);

    logic                            s1_valid_q, s1_valid_d;
    logic [LANES-1:0]                s1_sign_q, s1_sign_d;
    logic [LANES-1:0][ACC_W-1:0]     s1_mag_q, s1_mag_d;
    logic [LANES-1:0][LW-1:0]        s1_lead_q, s1_lead_d;

    logic                            s2_valid_q, s2_valid_d;
    logic [LANES*16-1:0]             out_bf16_q, out_bf16_d;
    logic [LANES-1:0]                out_ovf_q, out_ovf_d;
    logic [LANES-1:0]                out_unf_q, out_unf_d;

    logic                            s2_adv;
    logic                            in_ready;

    logic [LANES-1:0]                lane_sign;
    logic [LANES-1:0][ACC_W-1:0]     lane_mag;
    logic [LANES-1:0][LW-1:0]        lane_lead;

    logic [LANES-1:0][15:0]          lane_bf16;
    logic [LANES-1:0]                lane_ovf;
    logic [LANES-1:0]                lane_unf;
    logic [LANES-1:0]                norm_unused;

    // S2 can take a new beat when it is empty or its beat leaves this cycle.
    always_comb begin
        s2_adv   = !s2_valid_q || bus.out_ready;
        in_ready = !rst && (!s1_valid_q || s2_adv);
    end

    always_comb begin
        lane_sign = '0;
        lane_mag  = '0;
        lane_lead = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sign[i] = bus.in_acc[i*ACC_W + ACC_W - 1];
            lane_mag[i]  = lane_sign[i] ? (~bus.in_acc[i*ACC_W +: ACC_W] + 1'b1)
                                        : bus.in_acc[i*ACC_W +: ACC_W];
            for (int unsigned b = 0; b < ACC_W; b++) begin
                if (lane_mag[i][b]) begin
                    lane_lead[i] = LW'(b);
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lead_d  = s1_lead_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d = lane_sign;
                s1_mag_d  = lane_mag;
                s1_lead_d = lane_lead;
            end
        end
    end

    always_comb begin
        logic [LW-1:0]       shamt;
        logic [NW-1:0]       norm;
        logic [6:0]          man;
        logic [7:0]          man_r;
        logic                rnd;
        logic signed [9:0]   exp_v;
`ifdef ACC_BF16_RNE_EN
        logic                guard;
        logic                sticky;
`endif
        lane_bf16   = '0;
        lane_ovf    = '0;
        lane_unf    = '0;
        norm_unused = '0;
        shamt       = '0;
        norm        = '0;
        man         = '0;
        man_r       = '0;
        rnd         = 1'b0;
        exp_v       = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            shamt = LW'(ACC_W - 1) - s1_lead_q[i];
            norm  = {s1_mag_q[i], 9'b0} << shamt;
            man   = norm[NW-2 -: 7];
`ifdef ACC_BF16_RNE_EN
            guard          = norm[NW-9];
            sticky         = |norm[NW-10:0];
            rnd            = guard & (sticky | man[0]);
            norm_unused[i] = norm[NW-1];
`else
            rnd            = 1'b0;
            norm_unused[i] = ^{norm[NW-1], norm[NW-9:0]};
`endif
            // A carry out of the mantissa leaves man_r[6:0] at zero and bumps the exponent.
            man_r = {1'b0, man} + {7'b0, rnd};
            exp_v = $signed({{(10-LW){1'b0}}, s1_lead_q[i]}) + EXP_BIAS
                  + $signed({9'b0, man_r[7]});
            if (s1_mag_q[i] == '0) begin
                lane_bf16[i] = 16'h0000;
            end else if (exp_v >= 10'sd255) begin
                lane_bf16[i] = {s1_sign_q[i], 8'hFF, 7'h00};
                lane_ovf[i]  = 1'b1;
            end else if (exp_v <= 10'sd0) begin
                lane_bf16[i] = {s1_sign_q[i], 15'h0000};
                lane_unf[i]  = 1'b1;
            end else begin
                lane_bf16[i] = {s1_sign_q[i], exp_v[7:0], man_r[6:0]};
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_bf16_d = out_bf16_q;
        out_ovf_d  = out_ovf_q;
        out_unf_d  = out_unf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_bf16_d = lane_bf16;
                out_ovf_d  = lane_ovf;
                out_unf_d  = lane_unf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= '0;
            s1_mag_q   <= '0;
            s1_lead_q  <= '0;
            s2_valid_q <= 1'b0;
            out_bf16_q <= '0;
            out_ovf_q  <= '0;
            out_unf_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_lead_q  <= s1_lead_d;
            s2_valid_q <= s2_valid_d;
            out_bf16_q <= out_bf16_d;
            out_ovf_q  <= out_ovf_d;
            out_unf_q  <= out_unf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_bf16  = out_bf16_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;
endmodule
